// File: rtl/penc_norm_pipe.sv
// penc_norm_pipe
//
// Two-stage pipelined priority encoder and normaliser with valid/ready
// handshakes on both sides.
//
// Stage 1 finds the selected set bit of the incoming word and registers it
// along with the word, the mode, the all-zero flag and the zero count.
// Stage 2 applies the normalising shift and registers every output field.
//
// Mode 0 (MSB priority):
//   out_pos  = index of the highest set bit
//   out_cnt  = leading-zero count
//   out_norm = word shifted left by out_cnt
// Mode 1 (LSB priority):
//   out_pos  = index of the lowest set bit
//   out_cnt  = trailing-zero count
//   out_norm = word shifted right (logical) by out_cnt
// An all-zero word gives out_zero=1, out_pos=0, out_cnt=WIDTH and out_norm=0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input word offered
//   in_ready   block accepts the input word this cycle
//   in_data    word to encode (WIDTH bits)
//   in_mode    0 = MSB priority, 1 = LSB priority
//   out_valid  result present
//   out_ready  consumer takes the result
//   out_pos    bit index of the selected set bit (LW bits)
//   out_zero   input word was all zeros
//   out_cnt    leading- or trailing-zero count (LW+1 bits)
//   out_norm   normalised word (WIDTH bits)

module penc_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int LW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    out_pos,
  output logic             out_zero,
  output logic [LW:0]      out_cnt,
  output logic [WIDTH-1:0] out_norm
);

  localparam logic [LW:0] TOP_IDX      = (LW+1)'(WIDTH-1);
  localparam logic [LW:0] ALL_ZERO_CNT = (LW+1)'(WIDTH);

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;
  logic [LW-1:0]    s1_pos;
  logic             s1_zero;
  logic [LW:0]      s1_cnt;

  // Encoder results for the word currently on in_data
  logic [LW-1:0]    enc_pos;
  logic             enc_zero;
  logic [LW:0]      enc_cnt;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] shifted;

  // out_valid doubles as the stage 2 valid flag. The load enables depend
  // only on register state and out_ready, so in_valid never reaches in_ready.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Priority encoder: the loop direction makes the last hit win, so the
  // ascending scan yields the highest set bit and the descending scan the
  // lowest one.
  always_comb begin
    enc_pos  = '0;
    enc_zero = (in_data == '0);
    if (in_mode) begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (in_data[i]) enc_pos = LW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_data[i]) enc_pos = LW'(i);
      end
    end
    if (enc_zero) begin
      enc_cnt = ALL_ZERO_CNT;
    end else if (in_mode) begin
      enc_cnt = {1'b0, enc_pos};
    end else begin
      enc_cnt = TOP_IDX - {1'b0, enc_pos};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
      s1_cnt   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
        s1_pos  <= enc_pos;
        s1_zero <= enc_zero;
        s1_cnt  <= enc_cnt;
      end
    end
  end

  // A zero word carries cnt=WIDTH; shifting it by the full width still
  // yields zero, so no special case is needed here.
  always_comb begin
    shifted = s1_mode ? (s1_data >> s1_cnt) : (s1_data << s1_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_zero  <= 1'b0;
      out_cnt   <= '0;
      out_norm  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pos  <= s1_pos;
        out_zero <= s1_zero;
        out_cnt  <= s1_cnt;
        out_norm <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_penc_norm_pipe.sv
// Testbench for penc_norm_pipe at WIDTH=32: directed vectors with
// hand-computed results, backpressure, mid-flight reset and a randomised
// stream checked against an independent zero-counting model.

module tb_penc_norm_pipe;

  localparam int WIDTH = 32;
  localparam int LW    = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    out_pos;
  logic             out_zero;
  logic [LW:0]      out_cnt;
  logic [WIDTH-1:0] out_norm;

  typedef struct packed {
    logic [4:0]  pos;
    logic        zero;
    logic [5:0]  cnt;
    logic [31:0] norm;
  } res_t;

  res_t expq[$];
  int   checks     = 0;
  int   failures   = 0;
  int   acc_count  = 0;
  int   pop_count  = 0;
  logic last_acc   = 1'b0;

  penc_norm_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_zero  (out_zero),
    .out_cnt   (out_cnt),
    .out_norm  (out_norm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: counts zeros from the priority end, then derives the rest.
  function automatic res_t model(input logic [31:0] d, input logic m);
    res_t r;
    int   n;
    r = '0;
    if (d == 32'h0) begin
      r.zero = 1'b1;
      r.cnt  = 6'd32;
      return r;
    end
    n = 0;
    if (!m) begin
      while (d[31-n] == 1'b0) n++;
      r.pos  = 5'(31 - n);
      r.norm = d << n;
    end else begin
      while (d[n] == 1'b0) n++;
      r.pos  = 5'(n);
      r.norm = d >> n;
    end
    r.cnt = 6'(n);
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  // One clock cycle: observe handshakes at the negedge, then step past the posedge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        pop_count++;
        if (expq.size() == 0) begin
          checkOutput("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          checkOutput("sb_pos",  64'(out_pos),  64'(e.pos));
          checkOutput("sb_zero", 64'(out_zero), 64'(e.zero));
          checkOutput("sb_cnt",  64'(out_cnt),  64'(e.cnt));
          checkOutput("sb_norm", 64'(out_norm), 64'(e.norm));
        end
      end
      if (in_valid && in_ready) begin
        acc_count++;
        last_acc = 1'b1;
        expq.push_back(model(in_data, in_mode));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    expq.delete();
    acc_count = 0;
    pop_count = 0;
    rst_n = 1'b1;
  endtask

  // Sends one word into an empty pipe and checks the hand-computed result
  // two edges later.
  task automatic directed(input string tag, input logic [31:0] d, input logic m,
                          input int pos, input int cnt, input logic [31:0] norm, input logic zero);
    out_ready = 1'b1;
    applyStimulus(1'b1, d, m);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_pos"},   64'(out_pos),   64'(pos));
    checkOutput({tag, "_cnt"},   64'(out_cnt),   64'(cnt));
    checkOutput({tag, "_norm"},  64'(out_norm),  64'(norm));
    checkOutput({tag, "_zero"},  64'(out_zero),  64'(zero));
    tick();
    checkOutput({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        mode_next;
    int          guard;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;

    // Reset state
    applyReset();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_pos",   64'(out_pos),   64'd0);
    checkOutput("rst_out_zero",  64'(out_zero),  64'd0);
    checkOutput("rst_out_cnt",   64'(out_cnt),   64'd0);
    checkOutput("rst_out_norm",  64'(out_norm),  64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);

    // Directed vectors
    directed("m0_bit16", 32'h0001_0000, 1'b0, 16, 15, 32'h8000_0000, 1'b0);
    directed("m0_ones",  32'hFFFF_FFFF, 1'b0, 31,  0, 32'hFFFF_FFFF, 1'b0);
    directed("m1_a00",   32'h0000_0A00, 1'b1,  9,  9, 32'h0000_0005, 1'b0);
    directed("m0_zero",  32'h0000_0000, 1'b0,  0, 32, 32'h0000_0000, 1'b1);
    directed("m1_zero",  32'h0000_0000, 1'b1,  0, 32, 32'h0000_0000, 1'b1);
    directed("m0_bit0",  32'h0000_0001, 1'b0,  0, 31, 32'h8000_0000, 1'b0);
    directed("m1_bit31", 32'h8000_0000, 1'b1, 31, 31, 32'h0000_0001, 1'b0);

    // Backpressure: three words offered while the consumer stalls
    applyReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0003, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
    tick();
    tick();
    checkOutput("bp_accepted",     64'(acc_count), 64'd2);
    checkOutput("bp_in_ready",     64'(in_ready),  64'd0);
    checkOutput("bp_hold_valid",   64'(out_valid), 64'd1);
    checkOutput("bp_hold_pos",     64'(out_pos),   64'd8);
    checkOutput("bp_hold_cnt",     64'(out_cnt),   64'd23);
    checkOutput("bp_hold_norm",    64'(out_norm),  64'h8000_0000);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_pop_and_accept", 64'(acc_count), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("bp_drain_pops",  64'(pop_count),   64'd3);
    checkOutput("bp_queue_empty", 64'(expq.size()), 64'd0);
    checkOutput("bp_idle_valid",  64'(out_valid),   64'd0);

    // Reset with two words in flight
    applyReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_F000, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0010, 1'b1);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    expq.delete();
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);

    // Random stream with alternating modes and random consumer stalls
    applyReset();
    mode_next = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'h1 << $urandom_range(0, 31);
        2:       d = $urandom;
        default: d = $urandom & $urandom & $urandom;
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), d, mode_next);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc) mode_next = ~mode_next;
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    guard = 0;
    while (expq.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("rand_drained", 64'(expq.size()), 64'd0);
    checkOutput("rand_all_out", 64'(pop_count), 64'(acc_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
